bus_master_dma: RTL
===================

BUS_MASTER_DMA -- requirements
Module: bus_master_dma

Interface
REQ-001 Parameter CNT_W, default 16: width of the transfer word count.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst  input  1  synchronous active-low reset; the block is in reset while rst is 0 at a rising edge of clk.
REQ-004 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 src_addr  input  32  source byte address; bits [1:0] ignored.
REQ-006 dst_addr  input  32  destination byte address; bits [1:0] ignored.
REQ-007 word_count  input  CNT_W  number of 32-bit words to copy.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse on completion or abort.
REQ-010 err  output  1  sticky: last transfer aborted on bus error; cleared by the next accepted start.
REQ-011 data_req  output  1  bus request.
REQ-012 data_we  output  1  1 = write, 0 = read.
REQ-013 data_be  output  4  byte enables; always 4'b1111.
REQ-014 data_addr  output  32  word-aligned bus address; bits [1:0] always 0.
REQ-015 data_wdata  output  32  write data.
REQ-016 data_gnt  input  1  responder accepted the current request.
REQ-017 data_rvalid  input  1  response valid.
REQ-018 data_rdata  input  32  read data, valid with data_rvalid.
REQ-019 data_err  input  1  error flag, valid with data_rvalid.

Function
REQ-020 States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN; all outputs are registered.
REQ-021 IDLE + start=1: latch src/dst (bits [1:0] cleared) and word_count, clear err, set busy; go to RD_REQ, or to FIN if word_count=0 (no bus traffic).
REQ-022 RD_REQ: data_req=1, data_we=0, data_addr=current source; hold data_req and all request signals stable until data_gnt=1 at a clock edge, then drop data_req and go to RD_WAIT.
REQ-023 RD_WAIT: on data_rvalid=1 with data_err=0, capture data_rdata into the write buffer and go to WR_REQ; with data_err=1, set err and go to FIN.
REQ-024 WR_REQ: data_req=1, data_we=1, data_addr=current destination, data_wdata=buffer; hold until data_gnt=1, then go to WR_WAIT.
REQ-025 WR_WAIT: on data_rvalid=1 with data_err=1, set err and go to FIN; with data_err=0, increment both addresses by 4 (32-bit wrap, 0xFFFFFFFC+4=0), decrement remaining count, go to RD_REQ if remaining count is nonzero, else FIN.
REQ-026 FIN: pulse done=1 for one cycle, clear busy, return to IDLE.
REQ-027 At most one outstanding transaction; a new request is never issued before the previous response.
REQ-028 data_rvalid is ignored in IDLE, RD_REQ, WR_REQ and FIN.
REQ-029 data_rvalid in the same cycle as data_gnt is ignored; the response is taken no earlier than the cycle after grant.
REQ-030 start while busy is ignored and has no effect on latched parameters.
REQ-031 Latency: start in cycle N drives data_req=1 in cycle N+1; final accepted write response in cycle M gives done=1 in cycle M+1.
REQ-032 data_req is 0 in every state other than RD_REQ and WR_REQ; data_be is constant 4'b1111.

Reset
REQ-033 Reset values: state IDLE, data_req=0, data_we=0, data_addr=0, data_wdata=0, busy=0, done=0, err=0, internal counters and buffer 0.
REQ-034 Reset asserted mid-transfer aborts immediately with no done pulse; a late response after reset is ignored per REQ-028.

Configuration
REQ-035 Macro DMA_IRQ_EN: when defined, add output irq (1 bit), set to 1 in the cycle done pulses, held until the next accepted start or reset; when undefined, port irq does not exist and behaviour is otherwise identical.

Verification
REQ-036 src=0x1000, dst=0x2000, count=3, zero-wait responder -> reads 0x1000/4/8 and writes 0x2000/4/8 alternate, data copied exactly, single done pulse, err=0.
REQ-037 Grant delayed 5 cycles per request -> data_req, data_addr, data_we and data_wdata stable across all 5 stall cycles; copy completes correctly.
REQ-038 count=0 -> no data_req ever, done pulses 2 cycles after start, busy high for 1 cycle.
REQ-039 data_err=1 on 2nd read of count=4 -> no further requests, err=1, done pulses, only 1 write issued.
REQ-040 src=0xFFFFFFFC, count=2 -> second read at 0x00000000; start pulsed while busy -> ignored.
REQ-041 rst=0 while WR_REQ pending -> data_req=0 the next cycle, busy=0, no done; with DMA_IRQ_EN, irq=1 after REQ-036 and cleared by next start.

Source files
------------

// File: rtl/bus_master_dma.sv
// rtl/bus_master_dma.sv - single-channel word-copy DMA bus master with one outstanding request.
// Define DMA_IRQ_EN to add the irq output, raised with done and held until the next accepted start.
module bus_master_dma #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             data_req,
  output logic             data_we,
  output logic [3:0]       data_be,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic             data_gnt,
  input  logic             data_rvalid,
  input  logic [31:0]      data_rdata,
  input  logic             data_err
`ifdef DMA_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  logic [2:0]       r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_wdata;
  logic [31:0]      r_addr;
  logic             r_req;
  logic             r_we;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_irq;
  logic [31:0]      w_src_next;
  logic             w_unused;

  assign w_src_next = r_src + 32'd4;
  assign w_unused   = &{1'b0, src_addr[1:0], dst_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src  <= {src_addr[31:2], 2'b00};
            r_dst  <= {dst_addr[31:2], 2'b00};
            r_cnt  <= word_count;
            r_err  <= 1'b0;
            r_irq  <= 1'b0;
            r_busy <= 1'b1;
            if (word_count == '0) begin
              r_state <= S_FIN;
            end else begin
              r_state <= S_RD_REQ;
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= {src_addr[31:2], 2'b00};
            end
          end
        end
        S_RD_REQ: begin
          if (data_gnt) begin
            r_req   <= 1'b0;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (data_rvalid) begin
            if (data_err) begin
              r_err   <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_wdata <= data_rdata;
              r_req   <= 1'b1;
              r_we    <= 1'b1;
              r_addr  <= r_dst;
              r_state <= S_WR_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (data_gnt) begin
            r_req   <= 1'b0;
            r_state <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (data_rvalid) begin
            if (data_err) begin
              r_err   <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_src <= w_src_next;
              r_dst <= r_dst + 32'd4;
              r_cnt <= r_cnt - CNT_W'(1);
              // Last word completes straight from here so done lands the cycle after the response.
              if (r_cnt == CNT_W'(1)) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_irq   <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_req   <= 1'b1;
                r_we    <= 1'b0;
                r_addr  <= w_src_next;
                r_state <= S_RD_REQ;
              end
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_irq   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign data_req   = r_req;
  assign data_we    = r_we;
  assign data_be    = 4'b1111;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;
`ifdef DMA_IRQ_EN
  assign irq = r_irq;
`else
  logic w_unused_irq;
  assign w_unused_irq = r_irq;
`endif

endmodule
